// File: rtl/serial_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_sequencer
//  Purpose  : Nibble-serial adder/subtractor. Accepts one operand set, adds
//             one 4-bit nibble per clock (LSB first) through a single 4-bit
//             slice, then presents the W-bit result with carry-out and
//             two's-complement overflow until the consumer takes it.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             in_valid/in_ready   - operand handshake (a, b, c_in, sub)
//             out_valid/out_ready - result handshake (sum, c_out, ovf)
//             busy            - high while nibbles are being processed
//  Revision : 1.0 - initial release
// ============================================================================
module serial_add_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   c_in,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   c_out,
   output logic                   ovf,
   output logic                   busy
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;        // already inverted for subtract
   logic [W-1:0]     sum_q;
   logic [IDX_W-1:0] idx_q;
   logic             carry_q;
   logic             c_out_q;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   // Single shared 4-bit add slice working on the current nibble.
   logic [3:0] w_a_nib;
   logic [3:0] w_b_nib;
   logic [4:0] w_slice;
   logic       w_c_msb;          // carry into the top bit of the slice

   assign w_a_nib = a_q[4*idx_q +: 4];
   assign w_b_nib = b_q[4*idx_q +: 4];
   assign w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, carry_q};
   // sum bit 3 = a3 ^ b3 ^ cin3, so the carry into bit 3 is recovered by XOR.
   assign w_c_msb = w_a_nib[3] ^ w_b_nib[3] ^ w_slice[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         c_out_q     <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  // Subtract is A + ~B + 1, so the slice never needs to know.
                  a_q        <= a;
                  b_q        <= b ^ {W{sub}};
                  carry_q    <= sub ? 1'b1 : c_in;
                  idx_q      <= '0;
                  state_q    <= S_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_RUN: begin
               sum_q[4*idx_q +: 4] <= w_slice[3:0];
               carry_q             <= w_slice[4];
               if (idx_q == C_LAST_IDX) begin
                  c_out_q     <= w_slice[4];
                  ovf_q       <= w_c_msb ^ w_slice[4];
                  idx_q       <= '0;
                  state_q     <= S_DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign c_out     = c_out_q;
   assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_sequencer
//  Purpose  : Self-checking bench for serial_add_sequencer (NIBBLES=4):
//             directed vector table, backpressure, reset-abort, reset
//             priority and randomized operations against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sequencer;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;
   logic         busy;

   int n_chk  = 0;
   int n_err  = 0;
   int hs_cnt = 0;
   int exp_hs = 0;

   serial_add_sequencer #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Count every completed result handshake to catch lost/duplicated results.
   always @(posedge clk) begin
      if (!rst && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain W-bit arithmetic plus signed range test for overflow.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                        input logic mc, input logic ms,
                        output logic [W-1:0] s, output logic co, output logic ov);
      logic [W:0] full;
      longint sa, sb, r;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      if (ms) begin
         s  = ma - mb;
         co = (ma >= mb);
         r  = sa - sb;
      end else begin
         full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
         s    = full[W-1:0];
         co   = full[W];
         r    = sa + sb + longint'(mc);
      end
      ov = (r > ((64'sd1 <<< (W-1)) - 1)) || (r < -(64'sd1 <<< (W-1)));
   endtask

   task automatic scramble();
      a    = W'($urandom);
      b    = W'($urandom);
      c_in = 1'($urandom);
      sub  = 1'($urandom);
   endtask

   // One full operation: offer, check latency, hold for rdly cycles, consume.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic ts,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input int gap, input int rdly, input string tag);
      int n;
      int lat;
      @(negedge clk);
      repeat (gap) begin
         scramble();
         @(negedge clk);
      end
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk({tag, " in_ready timeout"}, 64'(in_ready), 64'd1);
         return;
      end
      a = ta; b = tb_v; c_in = tc; sub = ts;
      in_valid  = 1'b1;
      out_ready = (rdly == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble();
      chk({tag, " busy after accept"}, {62'd0, busy, in_ready}, 64'b10);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         scramble();
      end
      chk({tag, " latency"}, 64'(lat), 64'(NIBBLES));
      chk({tag, " result"}, {out_valid, in_ready, busy, c_out, ovf, sum},
          {1'b1, 1'b0, 1'b0, ec, eo, es});
      if (rdly > 0) begin
         repeat (rdly) begin
            @(posedge clk); #1;
            scramble();
            in_valid = 1'($urandom);
            chk({tag, " hold"}, {out_valid, in_ready, c_out, ovf, sum},
                {1'b1, 1'b0, ec, eo, es});
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_hs++;
      chk({tag, " consumed"}, {out_valid, in_ready, busy, c_out, ovf, sum},
          {1'b0, 1'b1, 1'b0, ec, eo, es});
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [W-1:0] es;
      logic         ec, eo;
      logic [W-1:0] ra, rb;
      logic         rc, rs;

      vecs[0]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[5]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[7]  = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[8]  = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
      vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[10] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset state", {in_ready, out_valid, busy, c_out, ovf, sum},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});

      // Directed vectors with a mix of immediate and delayed consumption.
      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                vecs[i].s, vecs[i].co, vecs[i].ov, i % 2, i % 3,
                $sformatf("vec%0d", i));
      end

      // Backpressure: result held for 10 cycles while inputs toggle.
      run_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0, 0, 10, "bp");

      // Reset in the 2nd RUN cycle aborts the operation.
      @(negedge clk);
      a = 16'h0F0F; b = 16'h0101; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort state", {in_ready, out_valid, busy, c_out, ovf, sum},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1, "post-abort");

      // Reset wins over an input handshake in the same cycle.
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; in_valid = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      chk("rst priority", {in_ready, busy, sum}, {1'b1, 1'b0, 16'h0000});
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b0;

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         model(ra, rb, rc, rs, es, ec, eo);
         run_op(ra, rb, rc, rs, es, ec, eo,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                $sformatf("rnd%0d", i));
      end

      repeat (3) @(negedge clk);
      chk("handshake count", 64'(hs_cnt), 64'(exp_hs));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the operand width W = 4*NIBBLES bits; legal range 2..16.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B.
REQ-009 c_in  input  1  carry-in, used for add only.
REQ-010 sub  input  1  0 selects A+B+c_in; 1 selects A-B.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  W  result.
REQ-014 c_out  output  1  carry out of the MSB nibble.
REQ-015 ovf  output  1  two's-complement overflow.
REQ-016 busy  output  1  high in the RUN state.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-018 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE; busy = 1 only in RUN.
REQ-019 In IDLE, when in_valid && in_ready on a clock edge, the block SHALL latch a, b^{W{sub}}, and carry = sub ? 1 : c_in, clear the nibble index to 0, and enter RUN.
REQ-020 SHALL ignore a, b, c_in and sub while not in IDLE; latched operands are immune to input changes.
REQ-021 In RUN, each cycle SHALL add exactly one 4-bit nibble: nibble[idx] of A + nibble[idx] of B + carry, through a single combinational 4-bit add slice.
REQ-022 Each RUN cycle SHALL write the result into sum[4*idx+3:4*idx], update carry with the slice carry-out, and increment idx.
REQ-023 SHALL process nibbles LSB first, so idx runs 0..NIBBLES-1.
REQ-024 On the RUN cycle where idx = NIBBLES-1, the block SHALL set c_out to the slice carry-out and set ovf to (carry into bit W-1) XOR (carry out of bit W-1), then enter DONE.
REQ-025 Latency: the accept edge is edge k; out_valid SHALL rise after edge k+NIBBLES and stay high until the handshake.
REQ-026 In DONE, sum, c_out and ovf SHALL hold stable until out_valid && out_ready; on that edge the FSM SHALL return to IDLE.
REQ-027 Back-to-back operation: in_ready rises the cycle after the output handshake, so throughput is one operation per NIBBLES+2 cycles minimum.
REQ-028 Subtract: c_out = 1 SHALL mean no borrow (A >= B unsigned).
REQ-029 Add wrap: sum is modulo 2^W; the carry is reported only in c_out.
REQ-030 If out_ready is already high when DONE is entered, the handshake SHALL complete on the next edge.
REQ-031 sum, c_out and ovf SHALL not change in IDLE; they keep the last result after it is consumed.
REQ-032 A nibble index reaching NIBBLES SHALL never occur; the index wraps to 0 on leaving RUN.

Reset
REQ-033 On rst high at a clock edge, the block SHALL set FSM = IDLE, idx = 0, carry = 0, sum = 0, c_out = 0, ovf = 0.
REQ-034 Reset values SHALL give in_ready = 1, out_valid = 0, busy = 0 from the first cycle after reset.
REQ-035 Reset SHALL take priority over any handshake in the same cycle.
REQ-036 Reset during RUN or DONE SHALL abort the operation; no out_valid is produced for it.

Verification (NIBBLES=4)
REQ-037 a=0x0000, b=0x0000, sub=0, c_in=0 -> sum=0x0000, c_out=0, ovf=0; out_valid exactly 4 cycles after accept.
REQ-038 a=0xFFFF, b=0x0001, sub=0, c_in=0 -> sum=0x0000, c_out=1, ovf=0 (carry ripples across all nibbles).
REQ-039 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, c_out=0, ovf=1; then a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0, ovf=0.
REQ-040 Backpressure: out_ready held 0 for 10 cycles in DONE with inputs toggling -> sum, c_out and ovf stable, in_ready=0; result consumed on the first out_ready=1 edge.
REQ-041 rst asserted on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0; a new operation 0x1234+0x4321 then yields 0x5555.
REQ-042 Exhaustive random: 1000 operations with random a, b, c_in, sub, in_valid and out_ready gaps -> every result matches a W-bit arithmetic model; no operation is lost or duplicated.
